// File: rtl/lut_scan_sched_pkg.sv
// Shared types and helpers for the lookup-table scan sequencer.
package lut_scan_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_e;

   localparam logic [15:0] LUT_PAD = 16'd3;

   function automatic logic [31:0] idx(input logic [31:0] g, input logic [31:0] r,
                                       input int unsigned ih);
      return g * ih + r;
   endfunction

endpackage

// File: rtl/lut_scan_sched_if.sv
// Control, lookup and output-stream signals of the scan sequencer.
interface lut_scan_sched_if #(parameter int unsigned GW = 16);
   logic          start;
   logic [GW-1:0] cfg_groups;
   logic          busy;
   logic          done;
   logic [31:0]   lut_group;
   logic [31:0]   lut_row;
   logic [15:0]   lut_dout;
   logic          out_valid;
   logic          out_ready;
   logic [15:0]   out_data;
   logic [31:0]   out_idx;
   logic          out_last;

   modport slave (
      input  start, cfg_groups, lut_dout, out_ready,
      output busy, done, lut_group, lut_row, out_valid, out_data, out_idx, out_last
   );

   modport master (
      output start, cfg_groups, lut_dout, out_ready,
      input  busy, done, lut_group, lut_row, out_valid, out_data, out_idx, out_last
   );
endinterface

// File: rtl/lut_scan_sched_cnt.sv
// Nested row/group counter: row is fastest, wraps at IH-1 into the next group.
module lut_scan_cnt #(
   parameter int unsigned IH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        adv,
   input  logic [31:0] groups,
   output logic [31:0] g,
   output logic [31:0] r,
   output logic        last
);
   logic [31:0] g_q, g_d, r_q, r_d;
   logic        row_wrap;

   assign row_wrap = (r_q == 32'(IH - 1));

   always_comb begin
      g_d = g_q;
      r_d = r_q;
      if (clr) begin
         g_d = '0;
         r_d = '0;
      end else if (adv) begin
         if (row_wrap) begin
            r_d = '0;
            g_d = g_q + 32'd1;
         end else begin
            r_d = r_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         g_q <= '0;
         r_q <= '0;
      end else begin
         g_q <= g_d;
         r_q <= r_d;
      end
   end

   assign g    = g_q;
   assign r    = r_q;
   assign last = row_wrap && (g_q == groups - 32'd1);
endmodule

// File: rtl/lut_scan_sched.sv
// Walks every (group,row) pair through the external lookup and streams the codes out.
// Build option LUT_SCAN_SKIP_PAD_EN: pairs at or beyond CKK are skipped instead of emitted.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | driving pairs to the lookup, loading the output register
// DRAIN | final code held until downstream takes it
// FIN   | one-cycle done pulse, then back to IDLE
module lut_scan_sched
   import lut_scan_pkg::*;
#(
   parameter int unsigned IH  = 8,
   parameter int unsigned CKK = 72,
   parameter int unsigned GW  = 16
) (
   input logic            clk,
   input logic            rst_n,
   lut_scan_sched_if.slave bus
);
`ifdef LUT_SCAN_SKIP_PAD_EN
   localparam bit SKIP_EN = 1'b1;
`else
   localparam bit SKIP_EN = 1'b0;
`endif
   localparam logic [31:0] CKK_W = 32'(CKK);

   state_e        state_q, state_d;
   logic [GW-1:0] groups_q, groups_d;
   logic          busy_q, busy_d, done_q, done_d;
   logic          valid_q, valid_d, last_q, last_d;
   logic [15:0]   data_q, data_d;
   logic [31:0]   out_idx_q, out_idx_d;

   logic [31:0] groups32, cnt_g, cnt_r, cur_idx, total, lim;
   logic        cnt_last, cnt_clr, cnt_adv, xfer, load, skip_pair, is_last;

   lut_scan_cnt #(.IH(IH)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .adv   (cnt_adv),
      .groups(groups32),
      .g     (cnt_g),
      .r     (cnt_r),
      .last  (cnt_last)
   );

   assign groups32  = 32'(groups_q);
   assign cur_idx   = idx(cnt_g, cnt_r, IH);
   assign total     = groups32 * IH;
   assign lim       = (total < CKK_W) ? total : CKK_W;
   assign skip_pair = SKIP_EN && (cur_idx >= CKK_W);
   // With skipping, the final emitted code is the last in-range address, not the last pair.
   assign is_last   = SKIP_EN ? (cur_idx == lim - 32'd1) : cnt_last;
   assign xfer      = valid_q && bus.out_ready;
   assign load      = !valid_q || bus.out_ready;

   always_comb begin
      state_d   = state_q;
      groups_d  = groups_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      valid_d   = valid_q;
      last_d    = last_q;
      data_d    = data_q;
      out_idx_d = out_idx_q;
      cnt_clr   = 1'b0;
      cnt_adv   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               busy_d = 1'b1;
               if (bus.cfg_groups != '0) begin
                  groups_d = bus.cfg_groups;
                  cnt_clr  = 1'b1;
                  state_d  = RUN;
               end else begin
                  state_d  = FIN;
               end
            end
         end
         RUN: begin
            if (skip_pair) begin
               cnt_adv = 1'b1;
               if (xfer) valid_d = 1'b0;
               if (cnt_last) state_d = (valid_q && !bus.out_ready) ? DRAIN : FIN;
            end else if (load) begin
               data_d    = bus.lut_dout;
               out_idx_d = cur_idx;
               valid_d   = 1'b1;
               cnt_adv   = 1'b1;
               if (is_last) begin
                  last_d  = 1'b1;
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (xfer) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               state_d = FIN;
            end
         end
         FIN: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         groups_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         data_q    <= '0;
         out_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         groups_q  <= groups_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         data_q    <= data_d;
         out_idx_q <= out_idx_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.lut_group = cnt_g;
   assign bus.lut_row   = cnt_r;
   assign bus.out_valid = valid_q;
   assign bus.out_data  = data_q;
   assign bus.out_idx   = out_idx_q;
   assign bus.out_last  = last_q;
endmodule

// File: tb/tb_lut_scan_sched.sv
// Scoreboard bench for lut_scan_sched: two instances (IH=4/CKK=72 and IH=8/CKK=20).
module tb_lut_scan_sched;
   import lut_scan_pkg::*;

   typedef struct packed {
      logic [15:0] data;
      logic [31:0] idx;
      logic        last;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   lut_scan_sched_if #(.GW(16)) ia ();
   lut_scan_sched_if #(.GW(16)) ib ();

   lut_scan_sched #(.IH(4), .CKK(72), .GW(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
   lut_scan_sched #(.IH(8), .CKK(20), .GW(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

   logic [31:0] addr_b;
   assign ia.lut_dout = 16'(ia.lut_group * 32'd4 + ia.lut_row + 32'd100);
   assign addr_b      = ib.lut_group * 32'd8 + ib.lut_row;
   assign ib.lut_dout = (addr_b < 32'd20) ? 16'(addr_b + 32'd100) : LUT_PAD;

   int   checks = 0, failures = 0;
   exp_t qa[$], qb[$];
   int   xa = 0, xb = 0, da = 0, db = 0;
   int   last_xfer_a = 0, done_cyc_a = 0;
   bit   rmode = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic push_a(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.data = 16'(i + 100);
         e.idx  = 32'(i);
         e.last = (i == n - 1);
         qa.push_back(e);
      end
   endtask

   task automatic wait_done(input bit which, input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (which ? ib.done : ia.done) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s_done actual=timeout required=done_pulse", name);
      end
   endtask

   task automatic start_a(input logic [15:0] g);
      @(posedge clk); #1;
      ia.start = 1'b1;
      ia.cfg_groups = g;
      @(posedge clk); #1;
      ia.start = 1'b0;
   endtask

   // out_ready pattern 1,0,0,1 when rmode is set
   initial begin
      logic [3:0] pat;
      int k;
      pat = 4'b1001;
      k = 0;
      ia.out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         ia.out_ready = rmode ? pat[k % 4] : 1'b1;
         k++;
      end
   end

   initial begin : mon_a
      exp_t e;
      logic pv;
      logic [15:0] pd;
      logic [31:0] pi;
      logic pl;
      pv = 1'b0; pd = '0; pi = '0; pl = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pv = 1'b0;
         end else begin
            if (pv) begin
               check("a_stall_valid", 32'(ia.out_valid), 1);
               check("a_stall_data", 32'(ia.out_data), 32'(pd));
               check("a_stall_idx", ia.out_idx, pi);
               check("a_stall_last", 32'(ia.out_last), 32'(pl));
            end
            if (ia.out_valid && ia.out_ready) begin
               if (qa.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL a_unexpected_output actual_idx=%0d required=none", ia.out_idx);
               end else begin
                  e = qa.pop_front();
                  check("a_data", 32'(ia.out_data), 32'(e.data));
                  check("a_idx", ia.out_idx, e.idx);
                  check("a_last", 32'(ia.out_last), 32'(e.last));
               end
               xa++;
               last_xfer_a = cyc;
            end
            pv = ia.out_valid && !ia.out_ready;
            pd = ia.out_data; pi = ia.out_idx; pl = ia.out_last;
            if (ia.done) begin
               da++;
               done_cyc_a = cyc;
            end
         end
      end
   end

   initial begin : mon_b
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (ib.out_valid && ib.out_ready) begin
               if (qb.size() == 0) begin
                  checks++; failures++;
                  $display("FAIL b_unexpected_output actual_idx=%0d required=none", ib.out_idx);
               end else begin
                  e = qb.pop_front();
                  check("b_data", 32'(ib.out_data), 32'(e.data));
                  check("b_idx", ib.out_idx, e.idx);
                  check("b_last", 32'(ib.out_last), 32'(e.last));
               end
               xb++;
            end
            if (ib.done) db++;
         end
      end
   end

   initial begin : stim
      int d0, nb;
      bit hit;
      exp_t e;
      ia.start = 1'b0; ia.cfg_groups = '0;
      ib.start = 1'b0; ib.cfg_groups = '0; ib.out_ready = 1'b1;

      // reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(ia.busy), 0);
      check("rst_done", 32'(ia.done), 0);
      check("rst_valid", 32'(ia.out_valid), 0);
      check("rst_last", 32'(ia.out_last), 0);
      check("rst_data", 32'(ia.out_data), 0);
      check("rst_idx", ia.out_idx, 0);
      check("rst_group", ia.lut_group, 0);
      check("rst_row", ia.lut_row, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // plain scan, two groups, full throughput
      xa = 0; d0 = da;
      push_a(8);
      start_a(16'd2);
      @(negedge clk);
      check("t1_busy_run", 32'(ia.busy), 1);
      check("t1_valid_lat1", 32'(ia.out_valid), 0);
      @(negedge clk);
      check("t1_valid_lat2", 32'(ia.out_valid), 1);
      wait_done(1'b0, "t1");
      check("t1_busy_at_done", 32'(ia.busy), 0);
      check("t1_codes", 32'(xa), 8);
      check("t1_queue_empty", 32'(qa.size()), 0);
      check("t1_done_after_last", 32'(done_cyc_a), 32'(last_xfer_a + 2));
      repeat (3) @(negedge clk);
      check("t1_done_width", 32'(da - d0), 1);

      // backpressure 1,0,0,1
      xa = 0; rmode = 1'b1;
      push_a(8);
      start_a(16'd2);
      wait_done(1'b0, "t2");
      check("t2_codes", 32'(xa), 8);
      check("t2_queue_empty", 32'(qa.size()), 0);
      @(posedge clk); #1;
      rmode = 1'b0;

      // zero groups
      d0 = da;
      start_a(16'd0);
      @(negedge clk);
      check("t3_busy_fin", 32'(ia.busy), 1);
      check("t3_done_early", 32'(ia.done), 0);
      @(negedge clk);
      check("t3_done", 32'(ia.done), 1);
      check("t3_busy_at_done", 32'(ia.busy), 0);
      @(negedge clk);
      check("t3_done_gone", 32'(ia.done), 0);
      check("t3_busy_idle", 32'(ia.busy), 0);
      check("t3_done_count", 32'(da - d0), 1);

      // reset in the middle of a 16-code scan
      xa = 0; d0 = da;
      push_a(16);
      start_a(16'd4);
      hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (xa >= 3) begin
            hit = 1'b1;
            break;
         end
      end
      checks++;
      if (!hit) begin
         failures++;
         $display("FAIL t4_third_output actual=timeout required=3_outputs");
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      qa.delete();
      @(negedge clk);
      check("t4_valid_after_rst", 32'(ia.out_valid), 0);
      check("t4_busy_after_rst", 32'(ia.busy), 0);
      check("t4_group_after_rst", ia.lut_group, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check("t4_no_done", 32'(da - d0), 0);
      xa = 0;
      push_a(8);
      start_a(16'd2);
      wait_done(1'b0, "t4_restart");
      check("t4_restart_codes", 32'(xa), 8);
      check("t4_restart_queue", 32'(qa.size()), 0);

      // start held high: one scan, the next only from the done cycle
      xa = 0; d0 = da;
      push_a(8);
      push_a(8);
      @(posedge clk); #1;
      ia.start = 1'b1;
      ia.cfg_groups = 16'd2;
      wait_done(1'b0, "t5_first");
      check("t5_first_codes", 32'(xa), 8);
      check("t5_busy_at_done", 32'(ia.busy), 0);
      @(posedge clk); #1;
      ia.start = 1'b0;
      @(negedge clk);
      check("t5_second_started", 32'(ia.busy), 1);
      wait_done(1'b0, "t5_second");
      check("t5_total_codes", 32'(xa), 16);
      check("t5_queue_empty", 32'(qa.size()), 0);
      repeat (3) @(negedge clk);
      check("t5_done_count", 32'(da - d0), 2);

      // pad region on the IH=8, CKK=20 instance
`ifdef LUT_SCAN_SKIP_PAD_EN
      nb = 20;
`else
      nb = 24;
`endif
      xb = 0;
      for (int i = 0; i < nb; i++) begin
         e.data = (i < 20) ? 16'(i + 100) : 16'd3;
         e.idx  = 32'(i);
         e.last = (i == nb - 1);
         qb.push_back(e);
      end
      @(posedge clk); #1;
      ib.start = 1'b1;
      ib.cfg_groups = 16'd3;
      @(posedge clk); #1;
      ib.start = 1'b0;
      wait_done(1'b1, "t6");
      check("t6_codes", 32'(xb), 32'(nb));
      check("t6_queue_empty", 32'(qb.size()), 0);
      check("t6_done_count", 32'(db), 1);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
